// File: rtl/uart_fifo.sv
// Receive-path FIFO for the UART: each entry holds a character plus break/parity/framing flags.
// Popped slots are zeroed, so an empty head reads 0 and the error OR can span the whole array.
module uart_fifo #(
    parameter int fifo_width     = 11,
    parameter int fifo_depth     = 16,
    parameter int fifo_pointer_w = 4,
    parameter int fifo_counter_w = 5
) (
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic [fifo_width-1:0]     data_in,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      fifo_reset,
    input  logic                      reset_status,
    output logic [fifo_width-1:0]     data_out,
    output logic [fifo_counter_w-1:0] count,
    output logic                      overrun,
    output logic                      error_bit
);

    localparam logic [fifo_counter_w-1:0] full_count = fifo_counter_w'(fifo_depth);
    localparam logic [fifo_pointer_w-1:0] last_ptr   = fifo_pointer_w'(fifo_depth - 1);

    logic [fifo_width-1:0]     mem_r [fifo_depth];
    logic [fifo_pointer_w-1:0] wr_ptr_r;
    logic [fifo_pointer_w-1:0] rd_ptr_r;
    logic [fifo_counter_w-1:0] count_r;
    logic                      overrun_r;
    logic                      do_push_s;
    logic                      do_pop_s;
    logic                      set_overrun_s;
    logic                      error_s;

    function automatic logic [fifo_pointer_w-1:0] next_ptr(input logic [fifo_pointer_w-1:0] ptr);
        if (ptr == last_ptr) begin
            return '0;
        end else begin
            return ptr + fifo_pointer_w'(1);
        end
    endfunction

    // Decide which halves of a push/pop request are honoured this cycle.
    always_comb begin
        do_pop_s      = 1'b0;
        do_push_s     = 1'b0;
        set_overrun_s = 1'b0;
        if (pop && (count_r != '0)) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
        if (push && ((count_r != full_count) || do_pop_s)) begin
            do_push_s = 1'b1;
        end else if (push) begin
            set_overrun_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
    end

    // Storage, pointers, occupancy and sticky overrun.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            overrun_r <= 1'b0;
            for (int i = 0; i < fifo_depth; i++) begin
                mem_r[i] <= '0;
            end
        end else if (fifo_reset) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            overrun_r <= 1'b0;
            for (int i = 0; i < fifo_depth; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_pop_s) begin
                mem_r[rd_ptr_r] <= '0;
                rd_ptr_r        <= next_ptr(rd_ptr_r);
            end
            // Placed after the clear so a full-FIFO push+pop on the same slot keeps the new data.
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= data_in;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + fifo_counter_w'(1);
                2'b01:   count_r <= count_r - fifo_counter_w'(1);
                default: count_r <= count_r;
            endcase
            if (reset_status) begin
                overrun_r <= 1'b0;
            end else if (set_overrun_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    // Aggregate status flags across every slot.
    always_comb begin
        error_s = 1'b0;
        for (int i = 0; i < fifo_depth; i++) begin
            error_s = error_s | (|mem_r[i][2:0]);
        end
    end

    assign data_out  = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign overrun   = overrun_r;
    assign error_bit = error_s;

endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: directed scenarios plus random traffic checked against a queue model.
module tb_uart_fifo;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic [10:0] data_in;
    logic        push, pop, fifo_reset, reset_status;
    logic [10:0] data_out;
    logic [4:0]  count;
    logic        overrun, error_bit;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [10:0] q[$];
    bit          ov_m;

    always #5 clk = ~clk;

    uart_fifo dut (
        .clk(clk), .wb_rst_i(wb_rst_i), .data_in(data_in), .push(push), .pop(pop),
        .fifo_reset(fifo_reset), .reset_status(reset_status), .data_out(data_out),
        .count(count), .overrun(overrun), .error_bit(error_bit)
    );

    function automatic logic [10:0] m_head();
        return (q.size() > 0) ? q[0] : 11'h000;
    endfunction

    function automatic logic m_err();
        logic e = 1'b0;
        foreach (q[i]) e |= (q[i][2:0] != 3'b000);
        return e;
    endfunction

    function automatic logic [4:0] m_count();
        return 5'(q.size());
    endfunction

    task automatic model_step(input bit p, input bit o, input logic [10:0] d, input bit fr, input bit rs);
        bit set_ov = 1'b0;
        if (fr) begin
            q.delete();
            ov_m = 1'b0;
        end else begin
            if (p && o && q.size() > 0) begin
                void'(q.pop_front());
                q.push_back(d);
            end else if (p) begin
                if (q.size() < 16) q.push_back(d);
                else set_ov = 1'b1;
            end else if (o && q.size() > 0) begin
                void'(q.pop_front());
            end
            if (rs) ov_m = 1'b0;
            else if (set_ov) ov_m = 1'b1;
        end
    endtask

    task automatic tick(input bit p, input bit o, input logic [10:0] d, input bit fr, input bit rs);
        push = p; pop = o; data_in = d; fifo_reset = fr; reset_status = rs;
        @(posedge clk);
        model_step(p, o, d, fr, rs);
        #1;
        push = 1'b0; pop = 1'b0; fifo_reset = 1'b0; reset_status = 1'b0;
    endtask

    task automatic test_reset();
        total_cnt++; if (count !== 5'd0) $display("FAIL rst_init_count: got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (data_out !== 11'h000) $display("FAIL rst_init_data: got %0h want 0", data_out); else pass_cnt++;
        for (int i = 0; i < 17; i++) tick(1'b1, 1'b0, 11'h7FF, 1'b0, 1'b0);
        total_cnt++; if (overrun !== 1'b1) $display("FAIL rst_pre_overrun: got %0b want 1", overrun); else pass_cnt++;
        #2 wb_rst_i = 1'b1;
        q.delete(); ov_m = 1'b0;
        #1;
        total_cnt++; if (count !== 5'd0) $display("FAIL rst_async_count: got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (data_out !== 11'h000) $display("FAIL rst_async_data: got %0h want 0", data_out); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL rst_async_overrun: got %0b want 0", overrun); else pass_cnt++;
        total_cnt++; if (error_bit !== 1'b0) $display("FAIL rst_async_error: got %0b want 0", error_bit); else pass_cnt++;
        wb_rst_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_order();
        logic [10:0] vals [3] = '{11'h0A8, 11'h150, 11'h7F8};
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, vals[i], 1'b0, 1'b0);
        total_cnt++; if (count !== 5'd3) $display("FAIL order_count: got %0d want 3", count); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (data_out !== vals[i]) $display("FAIL order_head%0d: got %0h want %0h", i, data_out, vals[i]); else pass_cnt++;
            tick(1'b0, 1'b1, 11'h000, 1'b0, 1'b0);
        end
        total_cnt++; if (count !== 5'd0) $display("FAIL order_empty_count: got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (data_out !== 11'h000) $display("FAIL order_empty_data: got %0h want 0", data_out); else pass_cnt++;
    endtask

    task automatic test_full_overrun();
        for (int i = 0; i < 17; i++) tick(1'b1, 1'b0, 11'($urandom_range(0, 2047)), 1'b0, 1'b0);
        total_cnt++; if (count !== 5'd16) $display("FAIL full_count: got %0d want 16", count); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL full_overrun: got %0b want 1", overrun); else pass_cnt++;
        tick(1'b0, 1'b0, 11'h000, 1'b0, 1'b1);
        total_cnt++; if (overrun !== 1'b0) $display("FAIL full_status_clear: got %0b want 0", overrun); else pass_cnt++;
        total_cnt++; if (count !== 5'd16) $display("FAIL full_count_kept: got %0d want 16", count); else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            total_cnt++; if (data_out !== m_head()) $display("FAIL full_drain%0d: got %0h want %0h", i, data_out, m_head()); else pass_cnt++;
            tick(1'b0, 1'b1, 11'h000, 1'b0, 1'b0);
        end
        total_cnt++; if (count !== 5'd0) $display("FAIL full_drained: got %0d want 0", count); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) tick(1'b1, 1'b0, 11'($urandom_range(0, 2047)), 1'b0, 1'b0);
        tick(1'b1, 1'b1, 11'h555, 1'b0, 1'b0);
        total_cnt++; if (count !== 5'd16) $display("FAIL simul_full_count: got %0d want 16", count); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL simul_full_overrun: got %0b want 0", overrun); else pass_cnt++;
        total_cnt++; if (data_out !== m_head()) $display("FAIL simul_full_head: got %0h want %0h", data_out, m_head()); else pass_cnt++;
        total_cnt++; if (q[15] !== 11'h555) $display("FAIL simul_model_tail: got %0h want 555", q[15]); else pass_cnt++;
        tick(1'b0, 1'b0, 11'h000, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 11'h123, 1'b0, 1'b0);
        total_cnt++; if (count !== 5'd1) $display("FAIL simul_empty_count: got %0d want 1", count); else pass_cnt++;
        total_cnt++; if (data_out !== 11'h123) $display("FAIL simul_empty_data: got %0h want 123", data_out); else pass_cnt++;
        tick(1'b0, 1'b1, 11'h000, 1'b0, 1'b0);
    endtask

    task automatic test_error_flag();
        tick(1'b1, 1'b0, 11'h100, 1'b0, 1'b0);
        total_cnt++; if (error_bit !== 1'b0) $display("FAIL err_clean: got %0b want 0", error_bit); else pass_cnt++;
        tick(1'b1, 1'b0, 11'h204, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 11'h300, 1'b0, 1'b0);
        total_cnt++; if (error_bit !== 1'b1) $display("FAIL err_set: got %0b want 1", error_bit); else pass_cnt++;
        tick(1'b0, 1'b1, 11'h000, 1'b0, 1'b0);
        total_cnt++; if (error_bit !== 1'b1) $display("FAIL err_held: got %0b want 1", error_bit); else pass_cnt++;
        tick(1'b0, 1'b1, 11'h000, 1'b0, 1'b0);
        total_cnt++; if (error_bit !== 1'b0) $display("FAIL err_drop: got %0b want 0", error_bit); else pass_cnt++;
        tick(1'b0, 1'b1, 11'h000, 1'b0, 1'b0);
    endtask

    task automatic test_wrap_flush();
        for (int i = 0; i < 40; i++) begin
            bit p = (i % 2 == 0) || ($urandom_range(0, 1) == 1);
            bit o = (i % 2 == 1) && (q.size() > 2 || $urandom_range(0, 3) == 0);
            tick(p, o, 11'($urandom_range(0, 2047)), 1'b0, 1'b0);
            total_cnt++; if (data_out !== m_head()) $display("FAIL wrap_head%0d: got %0h want %0h", i, data_out, m_head()); else pass_cnt++;
            total_cnt++; if (count !== m_count()) $display("FAIL wrap_count%0d: got %0d want %0d", i, count, m_count()); else pass_cnt++;
        end
        for (int i = 0; i < 18; i++) tick(1'b1, 1'b0, 11'($urandom_range(0, 2047)), 1'b0, 1'b0);
        tick(1'b1, 1'b0, 11'h7FF, 1'b1, 1'b0);
        total_cnt++; if (count !== 5'd0) $display("FAIL flush_count: got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (data_out !== 11'h000) $display("FAIL flush_data: got %0h want 0", data_out); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL flush_overrun: got %0b want 0", overrun); else pass_cnt++;
        total_cnt++; if (error_bit !== 1'b0) $display("FAIL flush_error: got %0b want 0", error_bit); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bit p  = ($urandom_range(0, 99) < 55);
            bit o  = ($urandom_range(0, 99) < 45);
            bit rs = ($urandom_range(0, 99) < 5);
            bit fr = ($urandom_range(0, 99) < 2);
            tick(p, o, 11'($urandom_range(0, 2047)), fr, rs);
            total_cnt++; if (data_out !== m_head()) $display("FAIL rand_head%0d: got %0h want %0h", i, data_out, m_head()); else pass_cnt++;
            total_cnt++; if (count !== m_count()) $display("FAIL rand_count%0d: got %0d want %0d", i, count, m_count()); else pass_cnt++;
            total_cnt++; if (overrun !== ov_m) $display("FAIL rand_overrun%0d: got %0b want %0b", i, overrun, ov_m); else pass_cnt++;
            total_cnt++; if (error_bit !== m_err()) $display("FAIL rand_error%0d: got %0b want %0b", i, error_bit, m_err()); else pass_cnt++;
        end
    endtask

    initial begin
        wb_rst_i = 1'b1; push = 1'b0; pop = 1'b0; data_in = 11'h000;
        fifo_reset = 1'b0; reset_status = 1'b0; ov_m = 1'b0;
        #12 wb_rst_i = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_order();
        test_full_overrun();
        test_simultaneous();
        test_error_flag();
        test_wrap_flush();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
